// File: rtl/axi_rd_arb.sv
// ---------------------------------------------------------------------------
// axi_rd_arb
// Two-requester AXI read-channel arbiter sharing a single slave. One burst is
// outstanding at the slave at a time: IDLE picks an owner, ADDR forwards the
// owner's AR request, DATA routes R beats back to the owner until m_rlast.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   sN_ar*  (N=0,1)         : requester AR channel (araddr/arlen/arsize/arburst/arvalid in, arready out)
//   sN_r*   (N=0,1)         : requester R channel (rdata/rvalid/rlast out, rready in)
//   m_ar*                   : shared slave AR channel (payload/arvalid out, arready in)
//   m_r*                    : shared slave R channel (rdata/rvalid/rlast in, rready out)
//   grant                   : index of current owner, meaningful outside IDLE
//   len_err                 : one-cycle pulse on a burst-length mismatch
//
// Configuration
//   AXI_RD_ARB_FIXED_PRIO_EN : when defined, requester 0 always wins contention
//                              and no round-robin pointer is kept.
// ---------------------------------------------------------------------------
module axi_rd_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [3:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_rvalid,
  output logic              s0_rlast,
  input  logic              s0_rready,
  // requester 1
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [3:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_rvalid,
  output logic              s1_rlast,
  input  logic              s1_rready,
  // shared slave
  output logic [ADDR_W-1:0] m_araddr,
  output logic [3:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid,
  input  logic              m_rlast,
  output logic              m_rready,
  // status
  output logic              grant,
  output logic              len_err
);

  localparam int unsigned LEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             len_err_q, len_err_d;

  logic             any_req_c;
  logic             win_c;
  logic             r_hs_c;
  logic [LEN_W-1:0] g_arlen_c;

  assign any_req_c = s0_arvalid | s1_arvalid;
  assign g_arlen_c = grant_q ? s1_arlen : s0_arlen;
  assign r_hs_c    = (state_q == ST_DATA) & m_rvalid & m_rready;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it asks.
  assign win_c = ~s0_arvalid;
`else
  logic last_q, last_d;

  // A lone requester wins; under contention the one not granted last wins.
  always_comb begin
    win_c = ~s0_arvalid;
    if (s0_arvalid && s1_arvalid) begin
      win_c = ~last_q;
    end
  end

  // Pointer follows every grant decision made in IDLE.
  always_comb begin
    last_d = last_q;
    if ((state_q == ST_IDLE) && any_req_c) begin
      last_d = win_c;
    end
  end

  // Reset value 1 lets requester 0 win the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // State and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    len_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          grant_d = win_c;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_arready) begin
          len_d   = g_arlen_c;
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_hs_c) begin
          cnt_d     = cnt_q + LEN_W'(1);
          // Flag rlast arriving early/late versus the latched arlen; only
          // rlast terminates the burst regardless.
          len_err_d = m_rlast ^ (cnt_q == len_q);
          if (m_rlast) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Channel routing; everything not owned in the current state reads as 0.
  always_comb begin
    m_araddr   = grant_q ? s1_araddr  : s0_araddr;
    m_arlen    = grant_q ? s1_arlen   : s0_arlen;
    m_arsize   = grant_q ? s1_arsize  : s0_arsize;
    m_arburst  = grant_q ? s1_arburst : s0_arburst;
    m_arvalid  = (state_q == ST_ADDR);
    m_rready   = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s0_rlast   = 1'b0;
    s0_rdata   = '0;
    s1_rvalid  = 1'b0;
    s1_rlast   = 1'b0;
    s1_rdata   = '0;
    if (state_q == ST_ADDR) begin
      if (grant_q) begin
        s1_arready = m_arready;
      end else begin
        s0_arready = m_arready;
      end
    end
    if (state_q == ST_DATA) begin
      if (grant_q) begin
        m_rready  = s1_rready;
        s1_rvalid = m_rvalid;
        s1_rlast  = m_rlast;
        s1_rdata  = m_rdata;
      end else begin
        m_rready  = s0_rready;
        s0_rvalid = m_rvalid;
        s0_rlast  = m_rlast;
        s0_rdata  = m_rdata;
      end
    end
  end

  assign grant   = grant_q;
  assign len_err = len_err_q;

endmodule

// File: tb/tb_axi_rd_arb.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arb
// Self-checking bench for axi_rd_arb: a table of single-requester bursts plus
// hand-written contention and mid-burst reset sequences. Routed R beats are
// checked against a scoreboard queue filled when the slave side drives them.
// ---------------------------------------------------------------------------
module tb_axi_rd_arb;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] s0_araddr, s1_araddr, m_araddr;
  logic [3:0]        s0_arlen, s1_arlen, m_arlen;
  logic [2:0]        s0_arsize, s1_arsize, m_arsize;
  logic [1:0]        s0_arburst, s1_arburst, m_arburst;
  logic              s0_arvalid, s1_arvalid, m_arvalid;
  logic              s0_arready, s1_arready, m_arready;
  logic [DATA_W-1:0] s0_rdata, s1_rdata, m_rdata;
  logic              s0_rvalid, s1_rvalid, m_rvalid;
  logic              s0_rlast, s1_rlast, m_rlast;
  logic              s0_rready, s1_rready, m_rready;
  logic              grant;
  logic              len_err;

  axi_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid), .s0_rlast(s0_rlast), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid), .s1_rlast(s1_rlast), .s1_rready(s1_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
    .grant(grant), .len_err(len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int len_err_seen = 0;

  typedef struct {
    int                req;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t sb[$];

  typedef struct {
    int          req;
    logic [31:0] addr;
    logic [3:0]  len;
    int          ar_delay;
    int          nbeats;
    int          stall_at;
    int          stall_len;
    int          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int req, input logic [DATA_W-1:0] d, input logic l);
    beat_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: requester %0d got beat 0x%0h, expected none", req, d);
    end else begin
      e = sb.pop_front();
      chk("sb_req", 64'(req), 64'(e.req));
      chk("sb_data", 64'(d), 64'(e.data));
      chk("sb_last", 64'(l), 64'(e.last));
    end
  endtask

  // Output monitor: every R handshake seen by a requester consumes one expected beat.
  always @(negedge clk) begin
    if (s0_rvalid && s0_rready) sb_pop(0, s0_rdata, s0_rlast);
    if (s1_rvalid && s1_rready) sb_pop(1, s1_rdata, s1_rlast);
    if (len_err) len_err_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ar(input int req, input logic v, input logic [31:0] a, input logic [3:0] len);
    if (req == 0) begin
      s0_arvalid = v; s0_araddr = a; s0_arlen = len; s0_arsize = 3'd2; s0_arburst = 2'b01;
    end else begin
      s1_arvalid = v; s1_araddr = a; s1_arlen = len; s1_arsize = 3'd2; s1_arburst = 2'b01;
    end
  endtask

  task automatic set_rready(input int req, input logic v);
    if (req == 0) s0_rready = v;
    else          s1_rready = v;
  endtask

  function automatic logic rv(input int req);
    return (req == 0) ? s0_rvalid : s1_rvalid;
  endfunction

  function automatic logic [DATA_W-1:0] rd(input int req);
    return (req == 0) ? s0_rdata : s1_rdata;
  endfunction

  function automatic logic ar_rdy(input int req);
    return (req == 0) ? s0_arready : s1_arready;
  endfunction

  // Requester arvalid already raised while IDLE; expect ADDR after exactly one edge.
  task automatic addr_phase(input int req, input logic [31:0] a, input logic [3:0] len,
                            input int ar_delay);
    int n;
    tick();
    n = 1;
    while (!m_arvalid && n < 10) begin
      tick();
      n++;
    end
    chk("addr_entry_cycles", 64'(n), 64'(1));
    chk("grant", 64'(grant), 64'(req));
    chk("m_araddr", 64'(m_araddr), 64'(a));
    chk("m_arlen", 64'(m_arlen), 64'(len));
    chk("m_arsize", 64'(m_arsize), 64'(3'd2));
    m_arready = 1'b0;
    for (int i = 0; i < ar_delay; i++) begin
      #1;
      chk("arready_wait", 64'(ar_rdy(req)), 64'(0));
      tick();
    end
    m_arready = 1'b1;
    #1;
    chk("arready_fwd", 64'(ar_rdy(req)), 64'(1));
    chk("arready_other", 64'(ar_rdy(1 - req)), 64'(0));
    tick();
    m_arready = 1'b0;
    set_ar(req, 1'b0, a, len);
  endtask

  // Slave sends nbeats (rlast on the final one); requester may stall before beat stall_at.
  task automatic data_phase(input int req, input int nbeats, input int stall_at,
                            input int stall_len);
    beat_t e;
    for (int b = 0; b < nbeats; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = $urandom;
      m_rlast  = (b == nbeats - 1);
      if (b == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          set_rready(req, 1'b0);
          #1;
          chk("stall_m_rready", 64'(m_rready), 64'(0));
          chk("stall_rvalid", 64'(rv(req)), 64'(1));
          tick();
        end
      end
      set_rready(req, 1'b1);
      e.req  = req;
      e.data = m_rdata;
      e.last = m_rlast;
      sb.push_back(e);
      #1;
      chk("m_rready", 64'(m_rready), 64'(1));
      chk("other_rvalid", 64'(rv(1 - req)), 64'(0));
      chk("other_rdata", 64'(rd(1 - req)), 64'(0));
      tick();
    end
    // One edge after the rlast handshake the block is IDLE.
    chk("idle_m_arvalid", 64'(m_arvalid), 64'(0));
    chk("idle_m_rready", 64'(m_rready), 64'(0));
    chk("idle_rvalid", 64'(rv(req)), 64'(0));
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rdata  = '0;
    set_rready(req, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int n0;
  int second;

  initial begin
    rst = 1'b1;
    set_ar(0, 1'b0, 32'h0, 4'h0);
    set_ar(1, 1'b0, 32'h0, 4'h0);
    s0_rready = 1'b0; s1_rready = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;

    //        req  addr          len   ardly beats stall@ stalln err
    vecs[0] = '{0, 32'h000FF000, 4'd3,  2,  4,  -1, 0, 0};
    vecs[1] = '{1, 32'h12345678, 4'd3,  0,  4,   2, 3, 0};
    vecs[2] = '{0, 32'hABCD0000, 4'd3,  1,  3,  -1, 0, 1};
    vecs[3] = '{1, 32'h00000040, 4'd1,  0,  3,  -1, 0, 2};
    vecs[4] = '{0, 32'hFFFFFFFC, 4'd0,  0,  1,  -1, 0, 0};
    vecs[5] = '{1, 32'h80000000, 4'd15, 3, 16,  -1, 0, 0};

    do_reset();
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_len_err", 64'(len_err), 64'(0));
    chk("rst_m_arvalid", 64'(m_arvalid), 64'(0));
    chk("rst_m_rready", 64'(m_rready), 64'(0));
    chk("rst_arready", 64'({s0_arready, s1_arready}), 64'(0));

    // Single-requester bursts from the table.
    for (int i = 0; i < 6; i++) begin
      n0 = len_err_seen;
      set_ar(vecs[i].req, 1'b1, vecs[i].addr, vecs[i].len);
      addr_phase(vecs[i].req, vecs[i].addr, vecs[i].len, vecs[i].ar_delay);
      data_phase(vecs[i].req, vecs[i].nbeats, vecs[i].stall_at, vecs[i].stall_len);
      tick();
      chk("len_err_count", 64'(len_err_seen - n0), 64'(vecs[i].exp_err));
    end

    // Contention out of reset: s0 first, then the other side of the pointer.
    do_reset();
    set_ar(0, 1'b1, 32'h0000_1000, 4'd0);
    set_ar(1, 1'b1, 32'h0000_2000, 4'd0);
    addr_phase(0, 32'h0000_1000, 4'd0, 0);
    data_phase(0, 1, -1, 0);
    set_ar(0, 1'b1, 32'h0000_3000, 4'd0);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    second = 0;
`else
    second = 1;
`endif
    if (second == 0) begin
      addr_phase(0, 32'h0000_3000, 4'd0, 0);
      data_phase(0, 1, -1, 0);
      set_ar(1, 1'b1, 32'h0000_2000, 4'd0);
      addr_phase(1, 32'h0000_2000, 4'd0, 0);
      data_phase(1, 1, -1, 0);
    end else begin
      set_ar(1, 1'b1, 32'h0000_2000, 4'd0);
      addr_phase(1, 32'h0000_2000, 4'd0, 0);
      data_phase(1, 1, -1, 0);
      set_ar(0, 1'b1, 32'h0000_3000, 4'd0);
      addr_phase(0, 32'h0000_3000, 4'd0, 0);
      data_phase(0, 1, -1, 0);
    end

    // Reset during beat 2 of an arlen=7 burst owned by s0.
    set_ar(0, 1'b1, 32'h0000_4000, 4'd7);
    addr_phase(0, 32'h0000_4000, 4'd7, 0);
    s0_rready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      beat_t e;
      m_rvalid = 1'b1;
      m_rlast  = 1'b0;
      m_rdata  = $urandom;
      e.req  = 0;
      e.data = m_rdata;
      e.last = 1'b0;
      sb.push_back(e);
      if (b == 2) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    m_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rst_mid_m_arvalid", 64'(m_arvalid), 64'(0));
    chk("rst_mid_m_rready", 64'(m_rready), 64'(0));
    chk("rst_mid_rvalid", 64'({s0_rvalid, s1_rvalid}), 64'(0));
    chk("rst_mid_arready", 64'({s0_arready, s1_arready}), 64'(0));
    chk("rst_mid_grant", 64'(grant), 64'(0));
    chk("rst_mid_len_err", 64'(len_err), 64'(0));
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    s0_rready = 1'b0;
    set_ar(0, 1'b1, 32'h0000_5000, 4'd0);
    set_ar(1, 1'b1, 32'h0000_6000, 4'd0);
    addr_phase(0, 32'h0000_5000, 4'd0, 0);
    data_phase(0, 1, -1, 0);
    addr_phase(1, 32'h0000_6000, 4'd0, 0);
    data_phase(1, 1, -1, 0);

    tick();
    tick();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/axi_rd_arb.md
AXI_RD_ARB -- requirements
Module: axi_rd_arb

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset: port clk (one clock), port rst (synchronous, active-high).
REQ-002 Parameter ADDR_W SHALL default to 32 and set the AXI read address width.
REQ-003 Parameter DATA_W SHALL default to 32 and set the AXI read data width.
REQ-004 The ports SHALL be as follows:
- clk, input, 1: system clock; all state updates on its rising edge.
- rst, input, 1: synchronous active-high reset.
- sN_araddr (N=0,1), input, ADDR_W: requester N read address.
- sN_arlen, input, 4: requester N burst length minus 1.
- sN_arsize, input, 3: requester N beat size.
- sN_arburst, input, 2: requester N burst type.
- sN_arvalid, input, 1: requester N address valid.
- sN_arready, output, 1: requester N address accepted.
- sN_rdata, output, DATA_W: requester N read data.
- sN_rvalid, output, 1: requester N data valid.
- sN_rlast, output, 1: requester N last beat.
- sN_rready, input, 1: requester N data ready.
- m_araddr / m_arlen / m_arsize / m_arburst, output, ADDR_W / 4 / 3 / 2: shared slave AR payload.
- m_arvalid, output, 1: shared slave AR valid.
- m_arready, input, 1: shared slave AR ready.
- m_rdata, input, DATA_W: shared slave read data.
- m_rvalid, input, 1: shared slave read valid.
- m_rlast, input, 1: shared slave read last.
- m_rready, output, 1: shared slave read ready.
- grant, output, 1: index of the current owner; valid outside IDLE.
- len_err, output, 1: one-cycle pulse flagging a burst-length mismatch.

Function
REQ-005 The block SHALL implement states IDLE, ADDR and DATA, with exactly one burst outstanding at the slave at any time.
REQ-006 IDLE: if any sN_arvalid is high, the block SHALL register grant and move to ADDR on the next edge; otherwise it SHALL stay in IDLE.
REQ-007 Arbitration SHALL be round-robin: with both requesters valid, the requester not granted last wins; with a single requester valid, that requester wins.
REQ-008 ADDR: m_ar* SHALL equal the granted sN_ar* combinationally, m_arvalid SHALL be 1, granted sN_arready SHALL equal m_arready, and the other sN_arready SHALL be 0.
REQ-009 ADDR: on the m_arvalid & m_arready handshake, the block SHALL latch arlen, clear the beat counter and move to DATA.
REQ-010 DATA: granted sN_rvalid/sN_rlast/sN_rdata SHALL equal m_rvalid/m_rlast/m_rdata; m_rready SHALL equal granted sN_rready.
REQ-011 The non-granted requester SHALL see rvalid=0, rlast=0 and rdata=0 in every state.
REQ-012 Each R handshake in DATA SHALL increment the 4-bit beat counter.
REQ-013 The R handshake carrying m_rlast SHALL return the block to IDLE on the next edge; the freed requester SHALL become eligible in that IDLE cycle.
REQ-014 Minimum turnaround SHALL be 1 IDLE cycle between the last-beat handshake and the next ADDR.
REQ-015 len_err SHALL pulse on the cycle after either of these events: an rlast handshake with counter != latched arlen, or a handshake with counter == arlen and rlast=0.
REQ-016 A len_err event SHALL NOT alter the state sequence; only rlast ends the burst.
REQ-017 In IDLE, m_arvalid, m_rready, all sN_arready and all sN_rvalid SHALL be 0.

Reset
REQ-018 While rst is high at a clock edge, the block SHALL set state to IDLE, grant to 0, the last-granted pointer to 1 (requester 0 wins first contention), the beat counter and latched arlen to 0, and len_err to 0.
REQ-019 Reset asserted mid-burst SHALL abort the burst with no further beats forwarded; the integrator SHALL reset the slave in the same cycle.

Configuration
REQ-020 Macro AXI_RD_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win contention and the pointer SHALL be unused; when undefined, arbitration SHALL be round-robin per REQ-007.

Verification
REQ-021 The bench SHALL cover: s0 only, araddr=0x000FF000, arlen=3, m_arready after 2 cycles -> 4 beats routed to s0, s1_rvalid=0 throughout, IDLE 1 cycle after rlast, len_err=0.
REQ-022 The bench SHALL cover: s0 and s1 valid together out of reset -> s0 granted first, then s1 (round-robin); with AXI_RD_ARB_FIXED_PRIO_EN and s0 re-requesting -> s0 twice.
REQ-023 The bench SHALL cover: arlen=3 with slave rlast on beat 2 -> len_err pulses once, return to IDLE after that beat.
REQ-024 The bench SHALL cover: s1 rready low 3 cycles mid-burst -> m_rready=0 and beat count held, no data lost.
REQ-025 The bench SHALL cover: rst high during beat 2 of an arlen=7 burst -> next cycle IDLE, all valid/ready outputs 0, then s0 wins the next contention.
